periph_reg_target: RTL and testbench

- Generic responder (slave) for one cluster peripheral-bus master port; the crossbar's speriph port drives it.
- Accepts req/gnt requests, decodes a word offset into a bank of NB_REGS 32-bit registers, and returns exactly one r_valid pulse per granted request, echoing the requester id.
- Exports the register bank to the host peripheral and accepts hardware-side register updates.
- Reused as the common front-end of simple cluster peripherals; also serves as the error slave when NB_REGS=0.

---
 rtl/pulp_cluster_package.sv | 36 +++
 rtl/periph_resp_timer.sv | 66 ++++++
 rtl/periph_reg_target.sv | 128 ++++++++++++
 tb/tb_periph_reg_target.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pulp_cluster_package.sv
// Shared cluster peripheral-bus definitions.
//   periph_resp_t   : response record {data, id, opc} used by targets and the crossbar
//   PERIPH_OPC_*    : response opcode values
//   tmr_state_e     : states of the response-latency timer
//   be_merge()      : byte-enable merge of new data over an old word
package pulp_cluster_package;

    localparam int unsigned PERIPH_ID_WIDTH = 9;
    localparam logic        PERIPH_OPC_OK   = 1'b0;
    localparam logic        PERIPH_OPC_ERR  = 1'b1;

    typedef struct packed {
        logic [31:0]                data;
        logic [PERIPH_ID_WIDTH-1:0] id;
        logic                       opc;
    } periph_resp_t;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_WAIT = 2'd1,
        TMR_RESP = 2'd2
    } tmr_state_e;

    // Bytes selected by be take new_v, the rest keep old_v.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/periph_resp_timer.sv
// Response-latency timer for periph_reg_target.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : accepted request (handshake) this cycle
//   busy_o        : timer not idle (target must not grant)
//   fire_o        : last WAIT cycle; the response is presented on the next cycle
// With WAIT_CYCLES == 0 the timer never leaves IDLE.
module periph_resp_timer
    import pulp_cluster_package::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic busy_o,
    output logic fire_o
);

    tmr_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_o  = 1'b0;
        busy_o  = (state_q != TMR_IDLE);
        case (state_q)
            TMR_IDLE: begin
                if (start_i && (WAIT_CYCLES != 32'd0)) begin
                    state_d = TMR_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 32'd1);
                end else begin
                    state_d = TMR_IDLE;
                end
            end
            TMR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = TMR_RESP;
                    fire_o  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            TMR_RESP: begin
                state_d = TMR_IDLE;
            end
            default: begin
                state_d = TMR_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TMR_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/periph_reg_target.sv
// Peripheral-bus register target: req/gnt front-end with a bank of NB_REGS
// 32-bit registers, one r_valid pulse per granted request (id echoed), and a
// hardware-side update port. With NB_REGS == 0 every access is an error.
//   bus request : req_i, add_i, wen_i (0 = write), wdata_i, be_i, id_i, gnt_o
//   response    : r_valid_o, r_rdata_o, r_opc_o (1 = error), r_id_o
//   host side   : regs_o (register bank), hw_we_i/hw_idx_i/hw_wdata_i
module periph_reg_target
    import pulp_cluster_package::*;
#(
    parameter int unsigned NB_REGS      = 8,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BE_WIDTH     = 4,
    parameter int unsigned ID_WIDTH     = 9,
    parameter int unsigned OFFSET_WIDTH = 10,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter logic [((NB_REGS > 0) ? NB_REGS : 1)-1:0] RO_MASK = '0
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            req_i,
    input  logic [ADDR_WIDTH-1:0]                           add_i,
    input  logic                                            wen_i,
    input  logic [DATA_WIDTH-1:0]                           wdata_i,
    input  logic [BE_WIDTH-1:0]                             be_i,
    input  logic [ID_WIDTH-1:0]                             id_i,
    output logic                                            gnt_o,
    output logic                                            r_valid_o,
    output logic [DATA_WIDTH-1:0]                           r_rdata_o,
    output logic                                            r_opc_o,
    output logic [ID_WIDTH-1:0]                             r_id_o,
    output logic [((NB_REGS > 0) ? NB_REGS : 1)*DATA_WIDTH-1:0] regs_o,
    input  logic                                            hw_we_i,
    input  logic [((NB_REGS > 1) ? $clog2(NB_REGS) : 1)-1:0] hw_idx_i,
    input  logic [DATA_WIDTH-1:0]                           hw_wdata_i
);

    // One storage slot is kept even for NB_REGS == 0; it can never be written.
    localparam int unsigned NR    = (NB_REGS > 0) ? NB_REGS : 1;
    localparam int unsigned IDX_W = OFFSET_WIDTH - 2;

    logic [NR-1:0][31:0] regs_q, regs_d;
    periph_resp_t        pend_q, pend_d;
    periph_resp_t        resp_q, resp_d;
    logic                r_valid_q, r_valid_d;

    logic                hs_s, gnt_s, busy_s, fire_s;
    logic [IDX_W-1:0]    idx_s;
    logic [NR-1:0]       sel_s;
    logic [31:0]         rd_data_s;
    logic                ro_hit_s, err_s, bus_wr_s, hw_ok_s;
    periph_resp_t        new_resp_s;
    logic                unused_addr_s;

    assign unused_addr_s = ^add_i[ADDR_WIDTH-1:OFFSET_WIDTH];

    periph_resp_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (hs_s),
        .busy_o  (busy_s),
        .fire_o  (fire_s)
    );

    // Request decode, register update and response selection.
    always_comb begin
        gnt_s     = ~busy_s;
        hs_s      = req_i & gnt_s;
        idx_s     = add_i[OFFSET_WIDTH-1:2];
        rd_data_s = 32'h0000_0000;
        ro_hit_s  = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            sel_s[i]  = (32'(idx_s) == 32'(i));
            rd_data_s = rd_data_s | (sel_s[i] ? regs_q[i] : 32'h0000_0000);
            ro_hit_s  = ro_hit_s | (sel_s[i] & RO_MASK[i]);
        end

        err_s = (add_i[1:0] != 2'b00) || (32'(idx_s) >= NB_REGS) ||
                (!wen_i && (ro_hit_s || (be_i == 4'b0000)));

        // Read data is taken from regs_q, i.e. before any same-edge update.
        new_resp_s.data = (wen_i && !err_s) ? rd_data_s : 32'h0000_0000;
        new_resp_s.id   = PERIPH_ID_WIDTH'(id_i);
        new_resp_s.opc  = err_s ? PERIPH_OPC_ERR : PERIPH_OPC_OK;

        // Hardware data first, then bus bytes on top: bus wins on enabled bytes.
        bus_wr_s = hs_s & ~wen_i & ~err_s;
        hw_ok_s  = hw_we_i && (32'(hw_idx_i) < NB_REGS);
        for (int i = 0; i < int'(NR); i++) begin
            regs_d[i] = (hw_ok_s && (32'(hw_idx_i) == 32'(i))) ? hw_wdata_i : regs_q[i];
            regs_d[i] = (bus_wr_s && sel_s[i]) ? be_merge(regs_d[i], wdata_i, be_i) : regs_d[i];
        end

        pend_d = hs_s ? new_resp_s : pend_q;
        if (WAIT_CYCLES == 32'd0) begin
            r_valid_d = hs_s;
            resp_d    = hs_s ? new_resp_s : resp_q;
        end else begin
            r_valid_d = fire_s;
            resp_d    = fire_s ? pend_q : resp_q;
        end
    end

    // Register bank, pending and presented response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q    <= '0;
            pend_q    <= '0;
            resp_q    <= '0;
            r_valid_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            resp_q    <= resp_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign gnt_o     = gnt_s;
    assign r_valid_o = r_valid_q;
    assign r_rdata_o = resp_q.data;
    assign r_opc_o   = resp_q.opc;
    assign r_id_o    = ID_WIDTH'(resp_q.id);
    assign regs_o    = regs_q;

endmodule

// File: tb/tb_periph_reg_target.sv
// Directed bench for periph_reg_target: three instances sharing the bus/hw
// inputs (separate req/reset): dut0 WAIT=0 RO_MASK=8'h02, dut2 WAIT=2, dut3 WAIT=3.
module tb_periph_reg_target;

    logic        clk, rst_n, rst2_n;
    logic        req0, req2, req3, wen, hw_we;
    logic [31:0] add, wdata, hw_wdata;
    logic [3:0]  be;
    logic [8:0]  id;
    logic [2:0]  hw_idx;

    logic        gnt0, rv0, opc0, gnt2, rv2, opc2, gnt3, rv3, opc3;
    logic [31:0] rd0, rd2, rd3;
    logic [8:0]  rid0, rid2, rid3;
    logic [255:0] regs0, regs2, regs3;

    int vec;
    int errs;

    periph_reg_target #(.NB_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h02)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt0), .r_valid_o(rv0),
        .r_rdata_o(rd0), .r_opc_o(opc0), .r_id_o(rid0), .regs_o(regs0),
        .hw_we_i(hw_we), .hw_idx_i(hw_idx), .hw_wdata_i(hw_wdata));

    periph_reg_target #(.NB_REGS(8), .WAIT_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .req_i(req2), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt2), .r_valid_o(rv2),
        .r_rdata_o(rd2), .r_opc_o(opc2), .r_id_o(rid2), .regs_o(regs2),
        .hw_we_i(hw_we), .hw_idx_i(hw_idx), .hw_wdata_i(hw_wdata));

    periph_reg_target #(.NB_REGS(8), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt3), .r_valid_o(rv3),
        .r_rdata_o(rd3), .r_opc_o(opc3), .r_id_o(rid3), .regs_o(regs3),
        .hw_we_i(hw_we), .hw_idx_i(hw_idx), .hw_wdata_i(hw_wdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One single-cycle access on dut0; returns gnt seen before the edge.
    task automatic acc0(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic [8:0] i, output logic g);
        add = a; wen = w; wdata = d; be = b; id = i; req0 = 1'b1;
        #1 g = gnt0;
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic test_reset();
        vec++; if (rv0 !== 1'b0)  begin errs++; $display("FAIL rst_rvalid0 got %0b want 0", rv0); end
        vec++; if (rd0 !== 32'h0) begin errs++; $display("FAIL rst_rdata0 got %h want 0", rd0); end
        vec++; if (opc0 !== 1'b0) begin errs++; $display("FAIL rst_opc0 got %0b want 0", opc0); end
        vec++; if (rid0 !== 9'h0) begin errs++; $display("FAIL rst_rid0 got %h want 0", rid0); end
        vec++; if (regs0 !== 256'h0) begin errs++; $display("FAIL rst_regs0 got %h want 0", regs0); end
        vec++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL rst_gnt0 got %0b want 1", gnt0); end
        vec++; if (gnt3 !== 1'b1 || rv3 !== 1'b0) begin errs++; $display("FAIL rst_dut3 gnt=%0b rv=%0b want 1/0", gnt3, rv3); end
    endtask

    task automatic test_write_read();
        logic g;
        acc0(32'h08, 1'b0, 32'hDEADBEEF, 4'hF, 9'h004, g);
        vec++; if (g !== 1'b1)    begin errs++; $display("FAIL wr_gnt got %0b want 1", g); end
        vec++; if (rv0 !== 1'b1)  begin errs++; $display("FAIL wr_rvalid got %0b want 1", rv0); end
        vec++; if (opc0 !== 1'b0) begin errs++; $display("FAIL wr_opc got %0b want 0", opc0); end
        vec++; if (rid0 !== 9'h004) begin errs++; $display("FAIL wr_rid got %h want 004", rid0); end
        vec++; if (rd0 !== 32'h0) begin errs++; $display("FAIL wr_rdata got %h want 0", rd0); end
        vec++; if (regs0[2*32 +: 32] !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_regs got %h want deadbeef", regs0[2*32 +: 32]); end
        @(posedge clk); #1;
        vec++; if (rv0 !== 1'b0 || rid0 !== 9'h004) begin errs++; $display("FAIL wr_pulse rv=%0b rid=%h want 0/004", rv0, rid0); end
        acc0(32'h08, 1'b1, 32'h0, 4'hF, 9'h010, g);
        vec++; if (rv0 !== 1'b1 || rd0 !== 32'hDEADBEEF || opc0 !== 1'b0 || rid0 !== 9'h010)
            begin errs++; $display("FAIL rd_08 rv=%0b data=%h opc=%0b id=%h want 1/deadbeef/0/010", rv0, rd0, opc0, rid0); end
    endtask

    task automatic test_byte_enable();
        logic g;
        acc0(32'h00, 1'b0, 32'h11223344, 4'b0101, 9'h001, g);
        acc0(32'h00, 1'b1, 32'h0, 4'hF, 9'h001, g);
        vec++; if (rd0 !== 32'h00220044 || opc0 !== 1'b0) begin errs++; $display("FAIL be_read data=%h opc=%0b want 00220044/0", rd0, opc0); end
    endtask

    task automatic test_errors();
        logic g;
        acc0(32'h03, 1'b1, 32'h0, 4'hF, 9'h002, g);
        vec++; if (rv0 !== 1'b1 || opc0 !== 1'b1 || rd0 !== 32'h0) begin errs++; $display("FAIL err_misalign rv=%0b opc=%0b data=%h want 1/1/0", rv0, opc0, rd0); end
        acc0(32'h20, 1'b1, 32'h0, 4'hF, 9'h002, g);
        vec++; if (opc0 !== 1'b1 || rd0 !== 32'h0) begin errs++; $display("FAIL err_range opc=%0b data=%h want 1/0", opc0, rd0); end
        acc0(32'h04, 1'b0, 32'hFFFFFFFF, 4'hF, 9'h002, g);
        vec++; if (opc0 !== 1'b1 || rd0 !== 32'h0) begin errs++; $display("FAIL err_ro opc=%0b data=%h want 1/0", opc0, rd0); end
        vec++; if (regs0[1*32 +: 32] !== 32'h0) begin errs++; $display("FAIL err_ro_reg got %h want 0", regs0[1*32 +: 32]); end
        acc0(32'h0C, 1'b0, 32'hFFFFFFFF, 4'h0, 9'h002, g);
        vec++; if (opc0 !== 1'b1 || regs0[3*32 +: 32] !== 32'h0) begin errs++; $display("FAIL err_be0 opc=%0b reg=%h want 1/0", opc0, regs0[3*32 +: 32]); end
        acc0(32'h04, 1'b1, 32'h0, 4'hF, 9'h002, g);
        vec++; if (opc0 !== 1'b0 || rd0 !== 32'h0) begin errs++; $display("FAIL ro_read opc=%0b data=%h want 0/0", opc0, rd0); end
    endtask

    task automatic test_back_to_back();
        add = 32'h10; wen = 1'b0; wdata = 32'h12345678; be = 4'hF; id = 9'h001; req0 = 1'b1;
        #1;
        vec++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL b2b_gnt_a got %0b want 1", gnt0); end
        @(posedge clk); #1;
        vec++; if (rv0 !== 1'b1 || rid0 !== 9'h001) begin errs++; $display("FAIL b2b_resp_a rv=%0b id=%h want 1/001", rv0, rid0); end
        wen = 1'b1; id = 9'h002;
        #1;
        vec++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL b2b_gnt_b got %0b want 1", gnt0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        vec++; if (rv0 !== 1'b1 || rid0 !== 9'h002 || rd0 !== 32'h12345678)
            begin errs++; $display("FAIL b2b_resp_b rv=%0b id=%h data=%h want 1/002/12345678", rv0, rid0, rd0); end
        @(posedge clk); #1;
        vec++; if (rv0 !== 1'b0) begin errs++; $display("FAIL b2b_idle rv=%0b want 0", rv0); end
    endtask

    task automatic test_collision();
        logic g;
        add = 32'h14; wen = 1'b0; wdata = 32'hAAAAAAAA; be = 4'b0011; id = 9'h004;
        hw_we = 1'b1; hw_idx = 3'd5; hw_wdata = 32'h55555555; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; hw_we = 1'b0;
        vec++; if (regs0[5*32 +: 32] !== 32'h5555AAAA) begin errs++; $display("FAIL coll_reg got %h want 5555aaaa", regs0[5*32 +: 32]); end
        vec++; if (regs3[5*32 +: 32] !== 32'h55555555) begin errs++; $display("FAIL coll_hw_only got %h want 55555555", regs3[5*32 +: 32]); end
        hw_we = 1'b1; hw_idx = 3'd1; hw_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        hw_we = 1'b0;
        vec++; if (regs0[1*32 +: 32] !== 32'h0BADF00D) begin errs++; $display("FAIL hw_ro_reg got %h want 0badf00d", regs0[1*32 +: 32]); end
        acc0(32'h14, 1'b1, 32'h0, 4'hF, 9'h008, g);
        vec++; if (rd0 !== 32'h5555AAAA || opc0 !== 1'b0) begin errs++; $display("FAIL coll_read data=%h opc=%0b want 5555aaaa/0", rd0, opc0); end
    endtask

    task automatic test_wait3();
        logic exp_rv, exp_gnt;
        add = 32'h04; wen = 1'b0; wdata = 32'hCAFEF00D; be = 4'hF; id = 9'h008; req3 = 1'b1;
        #1;
        vec++; if (gnt3 !== 1'b1) begin errs++; $display("FAIL w3_gnt_t got %0b want 1", gnt3); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            exp_rv  = (k == 4) || (k == 9);
            exp_gnt = (k == 5) || (k == 10);
            vec++; if (rv3 !== exp_rv || gnt3 !== exp_gnt)
                begin errs++; $display("FAIL w3_cycle%0d rv=%0b gnt=%0b want %0b/%0b", k, rv3, gnt3, exp_rv, exp_gnt); end
            if (k == 1) begin
                wen = 1'b1; id = 9'h020;
                vec++; if (regs3[1*32 +: 32] !== 32'hCAFEF00D) begin errs++; $display("FAIL w3_reg got %h want cafef00d", regs3[1*32 +: 32]); end
            end
            if (k == 4) begin
                vec++; if (rid3 !== 9'h008 || opc3 !== 1'b0 || rd3 !== 32'h0)
                    begin errs++; $display("FAIL w3_resp1 id=%h opc=%0b data=%h want 008/0/0", rid3, opc3, rd3); end
            end
            if (k == 6) begin
                req3 = 1'b0;
                vec++; if (rid3 !== 9'h008) begin errs++; $display("FAIL w3_hold id=%h want 008", rid3); end
            end
            if (k == 9) begin
                vec++; if (rid3 !== 9'h020 || rd3 !== 32'hCAFEF00D || opc3 !== 1'b0)
                    begin errs++; $display("FAIL w3_resp2 id=%h data=%h opc=%0b want 020/cafef00d/0", rid3, rd3, opc3); end
            end
        end
    endtask

    task automatic test_reset_mid();
        add = 32'h00; wen = 1'b0; wdata = 32'h00000077; be = 4'hF; id = 9'h040; req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        vec++; if (gnt2 !== 1'b0 || rv2 !== 1'b0) begin errs++; $display("FAIL rm_busy gnt=%0b rv=%0b want 0/0", gnt2, rv2); end
        rst2_n = 1'b0;
        #1;
        vec++; if (rv2 !== 1'b0 || rd2 !== 32'h0 || opc2 !== 1'b0 || rid2 !== 9'h0)
            begin errs++; $display("FAIL rm_outs rv=%0b data=%h opc=%0b id=%h want 0", rv2, rd2, opc2, rid2); end
        vec++; if (regs2 !== 256'h0) begin errs++; $display("FAIL rm_regs got %h want 0", regs2); end
        @(posedge clk); @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            vec++; if (rv2 !== 1'b0) begin errs++; $display("FAIL rm_norv cycle%0d rv=%0b want 0", k, rv2); end
        end
        wen = 1'b1; id = 9'h001; req2 = 1'b1;
        #1;
        vec++; if (gnt2 !== 1'b1) begin errs++; $display("FAIL rm_resume_gnt got %0b want 1", gnt2); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) req2 = 1'b0;
            vec++; if (rv2 !== (k == 3)) begin errs++; $display("FAIL rm_resume_rv cycle%0d rv=%0b want %0b", k, rv2, (k == 3)); end
            if (k == 3) begin
                vec++; if (rd2 !== 32'h0 || rid2 !== 9'h001 || opc2 !== 1'b0)
                    begin errs++; $display("FAIL rm_resume_resp data=%h id=%h opc=%0b want 0/001/0", rd2, rid2, opc2); end
            end
        end
    endtask

    initial begin
        vec = 0; errs = 0;
        rst_n = 1'b0; rst2_n = 1'b0;
        req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
        add = 32'h0; wen = 1'b1; wdata = 32'h0; be = 4'h0; id = 9'h0;
        hw_we = 1'b0; hw_idx = 3'd0; hw_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rst2_n = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_collision();
        test_wait3();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
